// File: rtl/lsq_pkg.sv
// -----------------------------------------------------------------------------
// lsq_pkg
// Shared types and helpers for the load-store queue memory stage.
//   ROB_W / PREG_W   : ROB-number and physical-register widths
//   SIZE_* / OP_*    : encodings of the size and op-type strobes
//   mem_op_t         : one in-flight operation as carried by the pipeline/skid
//   load_format()    : lane selection and sign extension of a loaded word
//   byte_enables()   : write strobes for a word or single-byte store
// -----------------------------------------------------------------------------
package lsq_pkg;

   localparam int ROB_W  = 6;
   localparam int PREG_W = 6;

   localparam logic SIZE_WORD = 1'b0;
   localparam logic SIZE_BYTE = 1'b1;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   typedef struct packed {
      logic              valid;
      logic [31:0]       pc;
      logic [ROB_W-1:0]  rob;
      logic [PREG_W-1:0] dest;
      logic              is_store;
      logic [31:0]       data;
   } mem_op_t;

   // Word loads return the whole word; byte loads pick the addressed lane
   // (lane 0 = bits 7:0) and sign-extend it.
   function automatic logic [31:0] load_format(input logic [31:0] word,
                                               input logic        size,
                                               input logic [1:0]  lane);
      logic [7:0] b;
      b = word[{lane, 3'b000} +: 8];
      if (size == SIZE_BYTE) begin
         return {{24{b[7]}}, b};
      end
      return word;
   endfunction

   function automatic logic [3:0] byte_enables(input logic       size,
                                               input logic [1:0] lane);
      if (size == SIZE_BYTE) begin
         return 4'b0001 << lane;
      end
      return 4'b1111;
   endfunction

endpackage

// File: rtl/lsq_mem_array.sv
// -----------------------------------------------------------------------------
// lsq_mem_array
// DEPTH_WORDS x 32-bit data memory with per-byte write strobes and a
// registered read port. Contents are cleared by the asynchronous reset so
// that loads after reset always return zero.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   wr_en, wr_be   write strobe and byte-lane enables (lane 0 = bits 7:0)
//   addr           word index shared by read and write
//   wr_data        write data (byte stores arrive replicated on all lanes)
//   rd_en          read strobe; rd_data updates on the same edge
//   rd_data        registered read data, holds between reads
// -----------------------------------------------------------------------------
module lsq_mem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wr_en,
   input  logic [3:0]    wr_be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Reads and writes are never requested on the same edge (one op per
   // cycle), so no read-during-write ordering is needed here.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[addr];
      end
   end

endmodule

// File: rtl/lsq_mem_stage.sv
// -----------------------------------------------------------------------------
// lsq_mem_stage
// Data-memory access stage below the LSQ issue port. One op per cycle:
//   - stores write the memory on the accept edge and complete MEM_LAT later
//   - memory loads read on the accept edge and complete MEM_LAT later
//   - loads already satisfied by the queue (in_from_lsq) go to a 1-entry
//     skid register and complete one cycle later unless the pipeline tail
//     owns the completion port that edge
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid / in_ready       issue handshake (accept on in_valid & in_ready)
//   in_pc, in_rob, in_dest    op identity (dest ignored for stores)
//   in_addr, in_size          byte address, 0 word / 1 byte
//   in_is_store, in_sw_data   op type and store data
//   in_from_lsq, in_lw_data   forwarded-load flag and its data
//   cmp_*                     registered completion broadcast toward ROB/CDB
// MEM_LAT must be in 2..8: stage 0 waits for the registered memory read,
// stage 1 captures and formats the read data.
// -----------------------------------------------------------------------------
module lsq_mem_stage
   import lsq_pkg::*;
#(
   parameter int MEM_LAT     = 3,
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_pc,
   input  logic [ROB_W-1:0]  in_rob,
   input  logic [PREG_W-1:0] in_dest,
   input  logic [31:0]       in_addr,
   input  logic              in_is_store,
   input  logic              in_size,
   input  logic [31:0]       in_sw_data,
   input  logic              in_from_lsq,
   input  logic [31:0]       in_lw_data,
   output logic              cmp_valid,
   output logic [31:0]       cmp_pc,
   output logic [ROB_W-1:0]  cmp_rob,
   output logic [PREG_W-1:0] cmp_dest,
   output logic [31:0]       cmp_data,
   output logic              cmp_is_store
);

   localparam int TAIL = MEM_LAT - 1;

   logic          accept;
   logic          fwd_acc;
   logic          mem_acc;
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;

   mem_op_t       acc_op;
   mem_op_t       stage1_op;
   mem_op_t       pipe_reg [MEM_LAT];
   mem_op_t       tail;
   logic          s0_size_reg;
   logic [1:0]    s0_lane_reg;

   mem_op_t       skid_reg;
   mem_op_t       skid_next;

   // Upper address bits only alias within the memory; they are not decoded.
   logic          unused_addr_hi;
   assign unused_addr_hi = ^in_addr[31:AW+2];

   // ---------------------------------------------------------------------
   // Issue handshake
   // ---------------------------------------------------------------------
   assign tail = pipe_reg[TAIL];

   // The only collision is skid and tail both holding a completion: the
   // tail wins, so the skid cannot take another forwarded load that edge.
   // Memory-path ops are fully pipelined and never need to stall.
   assign in_ready = ~(skid_reg.valid & tail.valid);

   assign accept  = in_valid & in_ready;
   assign fwd_acc = accept & (in_is_store == OP_LOAD) & in_from_lsq;
   assign mem_acc = accept & ~fwd_acc;

   // ---------------------------------------------------------------------
   // Data memory
   // ---------------------------------------------------------------------
   assign word_idx = in_addr[AW+1:2];
   assign lane     = in_addr[1:0];
   assign wr_be    = byte_enables(in_size, lane);
   assign wr_data  = (in_size == SIZE_BYTE) ? {4{in_sw_data[7:0]}} : in_sw_data;

   lsq_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (mem_acc & (in_is_store == OP_STORE)),
      .wr_be   (wr_be),
      .addr    (word_idx),
      .wr_data (wr_data),
      .rd_en   (mem_acc & (in_is_store == OP_LOAD)),
      .rd_data (rd_data)
   );

   // ---------------------------------------------------------------------
   // Memory-path pipeline
   // ---------------------------------------------------------------------
   always_comb begin
      acc_op          = '0;
      acc_op.valid    = mem_acc;
      acc_op.pc       = in_pc;
      acc_op.rob      = in_rob;
      acc_op.dest     = (in_is_store == OP_STORE) ? '0 : in_dest;
      acc_op.is_store = in_is_store;
      acc_op.data     = '0;
   end

   // Stage 0 has no data yet: the memory read lands in rd_data on the same
   // edge, so the size and lane are kept alongside to format it one stage on.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_reg[0]  <= '0;
         s0_size_reg  <= SIZE_WORD;
         s0_lane_reg  <= '0;
      end else begin
         pipe_reg[0]  <= acc_op;
         s0_size_reg  <= in_size;
         s0_lane_reg  <= lane;
      end
   end

   always_comb begin
      stage1_op      = pipe_reg[0];
      stage1_op.data = pipe_reg[0].is_store ? '0
                     : load_format(rd_data, s0_size_reg, s0_lane_reg);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_reg[1] <= '0;
      end else begin
         pipe_reg[1] <= stage1_op;
      end
   end

   for (genvar gi = 2; gi < MEM_LAT; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            pipe_reg[gi] <= '0;
         end else begin
            pipe_reg[gi] <= pipe_reg[gi-1];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Forwarded-load skid register
   // ---------------------------------------------------------------------
   always_comb begin
      skid_next = skid_reg;
      if (fwd_acc) begin
         // The skid can only be loaded when it is empty or draining this
         // edge, which in_ready guarantees.
         skid_next.valid    = 1'b1;
         skid_next.pc       = in_pc;
         skid_next.rob      = in_rob;
         skid_next.dest     = in_dest;
         skid_next.is_store = 1'b0;
         skid_next.data     = load_format(in_lw_data, in_size, 2'b00);
      end else if (!tail.valid) begin
         skid_next.valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         skid_reg <= '0;
      end else begin
         skid_reg <= skid_next;
      end
   end

   // ---------------------------------------------------------------------
   // Completion broadcast: tail has priority, skid fills idle slots.
   // Payload holds its last value when nothing completes.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cmp_valid    <= 1'b0;
         cmp_pc       <= '0;
         cmp_rob      <= '0;
         cmp_dest     <= '0;
         cmp_data     <= '0;
         cmp_is_store <= 1'b0;
      end else begin
         cmp_valid <= tail.valid | skid_reg.valid;
         if (tail.valid) begin
            cmp_pc       <= tail.pc;
            cmp_rob      <= tail.rob;
            cmp_dest     <= tail.dest;
            cmp_data     <= tail.data;
            cmp_is_store <= tail.is_store;
         end else if (skid_reg.valid) begin
            cmp_pc       <= skid_reg.pc;
            cmp_rob      <= skid_reg.rob;
            cmp_dest     <= skid_reg.dest;
            cmp_data     <= skid_reg.data;
            cmp_is_store <= skid_reg.is_store;
         end
      end
   end

endmodule

// File: tb/tb_lsq_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsq_mem_stage
// Directed vector table, hand-written async-reset sequence and a randomized
// run, all checked against a cycle-level reference model: a byte-addressed
// memory, a completion schedule keyed by cycle for memory-path ops, and a
// pending queue for forwarded loads.
// -----------------------------------------------------------------------------
module tb_lsq_mem_stage;

   localparam int MEM_LAT     = 3;
   localparam int DEPTH_WORDS = 256;
   localparam int BYTES       = DEPTH_WORDS * 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [5:0]  in_rob;
   logic [5:0]  in_dest;
   logic [31:0] in_addr;
   logic        in_is_store;
   logic        in_size;
   logic [31:0] in_sw_data;
   logic        in_from_lsq;
   logic [31:0] in_lw_data;
   logic        cmp_valid;
   logic [31:0] cmp_pc;
   logic [5:0]  cmp_rob;
   logic [5:0]  cmp_dest;
   logic [31:0] cmp_data;
   logic        cmp_is_store;

   lsq_mem_stage #(.MEM_LAT(MEM_LAT), .DEPTH_WORDS(DEPTH_WORDS)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rob(in_rob), .in_dest(in_dest), .in_addr(in_addr),
      .in_is_store(in_is_store), .in_size(in_size), .in_sw_data(in_sw_data),
      .in_from_lsq(in_from_lsq), .in_lw_data(in_lw_data),
      .cmp_valid(cmp_valid), .cmp_pc(cmp_pc), .cmp_rob(cmp_rob),
      .cmp_dest(cmp_dest), .cmp_data(cmp_data), .cmp_is_store(cmp_is_store)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [5:0]  rob;
      logic [5:0]  dest;
      logic [31:0] data;
      logic        st;
   } exp_t;

   exp_t       sched [int];
   exp_t       fwd_q [$];
   logic [7:0] mem_b [BYTES];
   exp_t       last;

   typedef struct {
      logic        v, st, sz, lsq;
      logic [31:0] addr, sw, lw;
      logic [5:0]  rob, dest;
      logic        er, ecv;
      logic [5:0]  erob, edest;
      logic [31:0] edata;
      logic        est;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, ncyc, act, exp);
      end
   endtask

   task automatic model_reset();
      sched.delete();
      fwd_q.delete();
      for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h00;
      last = '{pc: 0, rob: 0, dest: 0, data: 0, st: 0};
   endtask

   function automatic logic [31:0] sext8(input logic [7:0] b);
      return 32'($signed(b));
   endfunction

   function automatic logic [31:0] mload(input logic [31:0] a, input logic sz);
      int ba;
      ba = int'(a % BYTES);
      if (sz) return sext8(mem_b[ba]);
      ba = ba - (ba % 4);
      return {mem_b[ba+3], mem_b[ba+2], mem_b[ba+1], mem_b[ba]};
   endfunction

   task automatic mstore(input logic [31:0] a, input logic sz, input logic [31:0] d);
      int ba;
      ba = int'(a % BYTES);
      if (sz) begin
         mem_b[ba] = d[7:0];
      end else begin
         ba = ba - (ba % 4);
         for (int k = 0; k < 4; k++) mem_b[ba+k] = d[8*k +: 8];
      end
   endtask

   // One clock edge: check readiness, predict the completion for this edge,
   // apply the accepted op to the model, then sample outputs at the negedge.
   task automatic do_cycle();
      logic m_ready;
      logic have;
      exp_t eo;
      exp_t e;
      m_ready = !(fwd_q.size() > 0 && sched.exists(ncyc));
      chk("ready", 128'(in_ready), 128'(m_ready));
      have = 1'b0;
      eo   = last;
      if (sched.exists(ncyc)) begin
         eo = sched[ncyc];
         sched.delete(ncyc);
         have = 1'b1;
      end else if (fwd_q.size() > 0) begin
         eo = fwd_q.pop_front();
         have = 1'b1;
      end
      if (in_valid && m_ready) begin
         e.pc  = in_pc;
         e.rob = in_rob;
         if (in_is_store) begin
            mstore(in_addr, in_size, in_sw_data);
            e.dest = 0; e.data = 0; e.st = 1'b1;
            sched[ncyc + MEM_LAT] = e;
         end else if (in_from_lsq) begin
            e.dest = in_dest; e.st = 1'b0;
            e.data = in_size ? sext8(in_lw_data[7:0]) : in_lw_data;
            fwd_q.push_back(e);
         end else begin
            e.dest = in_dest; e.st = 1'b0;
            e.data = mload(in_addr, in_size);
            sched[ncyc + MEM_LAT] = e;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (have) begin
         chk("cmp", {cmp_valid, cmp_pc, cmp_rob, cmp_dest, cmp_data, cmp_is_store},
             {1'b1, eo.pc, eo.rob, eo.dest, eo.data, eo.st});
         $display("cyc %0d: cmp rob=%0d st=%0b dest=%0d data=%08h", ncyc, cmp_rob,
                  cmp_is_store, cmp_dest, cmp_data);
         last = eo;
      end else begin
         chk("idle_hold", {cmp_valid, cmp_pc, cmp_rob, cmp_dest, cmp_data, cmp_is_store},
             {1'b0, last.pc, last.rob, last.dest, last.data, last.st});
      end
      ncyc++;
   endtask

   task automatic set_in(input logic v, st, sz, lsq, input logic [31:0] addr, sw, lw,
                         input logic [5:0] rob, dest);
      in_valid = v; in_is_store = st; in_size = sz; in_from_lsq = lsq;
      in_addr = addr; in_sw_data = sw; in_lw_data = lw;
      in_rob = rob; in_dest = dest; in_pc = 32'h1000 + {24'h0, rob, 2'b00};
   endtask

   task automatic addv(input logic v, st, sz, lsq, input logic [31:0] addr, sw, lw,
                       input logic [5:0] rob, dest, input logic er, ecv,
                       input logic [5:0] erob, edest, input logic [31:0] edata,
                       input logic est);
      vec_t t;
      t.v = v; t.st = st; t.sz = sz; t.lsq = lsq; t.addr = addr; t.sw = sw; t.lw = lw;
      t.rob = rob; t.dest = dest; t.er = er; t.ecv = ecv; t.erob = erob;
      t.edest = edest; t.edata = edata; t.est = est;
      tbl.push_back(t);
   endtask

   initial begin
      logic r;
      logic keep;
      logic [5:0] rob_ctr;

      rstn = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", {in_ready, cmp_valid, cmp_pc, cmp_rob, cmp_dest, cmp_data, cmp_is_store},
          {1'b1, 1'b0, 32'h0, 6'h0, 6'h0, 32'h0, 1'b0});
      rstn = 1'b1;

      // ---- directed vector table (MEM_LAT = 3) ----
      //   v st sz lsq addr         sw           lw          rob dest | rdy cv rob dest data         st
      addv(1,1,0,0, 32'h40,  32'hDEADBEEF, 0,            1, 0,   1,0, 0,0, 0,            0);
      addv(1,0,0,0, 32'h40,  0,            0,            2, 5,   1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 1,0, 0,            1);
      addv(1,1,0,0, 32'h40,  32'h11223344, 0,            3, 0,   1,1, 2,5, 32'hDEADBEEF, 0);
      addv(1,1,1,0, 32'h41,  32'hABCDEF80, 0,            4, 0,   1,0, 0,0, 0,            0);
      addv(1,0,1,0, 32'h41,  0,            0,            5, 6,   1,0, 0,0, 0,            0);
      addv(1,0,0,0, 32'h43,  0,            0,            6, 7,   1,1, 3,0, 0,            1);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 4,0, 0,            1);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 5,6, 32'hFFFFFF80, 0);
      addv(1,0,0,1, 0,       0,            32'h1234,     7, 8,   1,1, 6,7, 32'h11228044, 0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 7,8, 32'h1234,     0);
      addv(1,0,1,1, 0,       0,            32'h7F,       8, 9,   1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 8,9, 32'h7F,       0);
      addv(1,0,1,1, 0,       0,            32'h1FE,      9, 10,  1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 9,10,32'hFFFFFFFE, 0);
      addv(1,1,0,0, 32'h400, 32'hA5,       0,            10,0,   1,0, 0,0, 0,            0);
      addv(1,0,0,0, 32'h0,   0,            0,            11,11,  1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 10,0,0,            1);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 11,11,32'hA5,      0);
      addv(1,0,0,0, 32'h40,  0,            0,            12,12,  1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,0, 0,0, 0,            0);
      addv(1,0,0,1, 0,       0,            32'h55,       13,13,  1,0, 0,0, 0,            0);
      addv(1,0,0,0, 32'h0,   0,            0,            14,14,  0,1, 12,12,32'h11228044,0);
      addv(1,0,0,0, 32'h0,   0,            0,            14,14,  1,1, 13,13,32'h55,      0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,0, 0,0, 0,            0);
      addv(0,0,0,0, 0,       0,            0,            0, 0,   1,1, 14,14,32'hA5,      0);

      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].v, tbl[i].st, tbl[i].sz, tbl[i].lsq, tbl[i].addr, tbl[i].sw,
                tbl[i].lw, tbl[i].rob, tbl[i].dest);
         r = in_ready;
         do_cycle();
         chk($sformatf("tbl%0d_ready", i), 128'(r), 128'(tbl[i].er));
         chk($sformatf("tbl%0d_valid", i), 128'(cmp_valid), 128'(tbl[i].ecv));
         if (tbl[i].ecv) begin
            chk($sformatf("tbl%0d_out", i), {cmp_rob, cmp_dest, cmp_data, cmp_is_store},
                {tbl[i].erob, tbl[i].edest, tbl[i].edata, tbl[i].est});
         end
      end

      // ---- asynchronous reset with ops in flight ----
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 0, 0, 32'h40, 0, 0, 6'(20 + i), 6'(20 + i));
         do_cycle();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rstn = 1'b0;
      #1;
      chk("rst_async", {in_ready, cmp_valid, cmp_pc, cmp_rob, cmp_dest, cmp_data, cmp_is_store},
          {1'b1, 1'b0, 32'h0, 6'h0, 6'h0, 32'h0, 1'b0});
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) do_cycle();
      set_in(1, 0, 0, 0, 32'h40, 0, 0, 30, 3);
      do_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < MEM_LAT; i++) do_cycle();
      chk("post_rst_lw", {cmp_rob, cmp_data}, {6'd30, 32'h0});

      // ---- randomized traffic; upstream holds an op until accepted ----
      rob_ctr = 6'd0;
      keep    = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!keep) begin
            set_in(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                   1'($urandom), ($urandom_range(0, 9) < 4),
                   $urandom & 32'h0000_0C3F, $urandom, $urandom, rob_ctr,
                   6'($urandom));
            if (in_valid) rob_ctr = rob_ctr + 6'd1;
         end
         r = in_ready;
         keep = in_valid && !r;
         do_cycle();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < MEM_LAT + 4; i++) do_cycle();
      chk("drained", 128'(sched.num() + fwd_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsq_mem_stage.md
Name: lsq_mem_stage

Overview:
- Data-memory access stage directly downstream of the load-store queue issue port.
- Accepts one issued load/store per cycle: stores write the internal data memory; loads read it through a fixed-latency pipeline.
- Loads already satisfied by the queue (from_lsq=1) bypass memory and complete through a 1-entry skid register.
- Produces a single registered completion broadcast (PC, ROB number, dest reg, data) toward ROB/CDB.

Parameters:
- MEM_LAT, 3, cycles from acceptance to completion for memory-path ops; legal range 2..8.
- DEPTH_WORDS, 256, data memory size in 32-bit words; power of two.
- AW, $clog2(DEPTH_WORDS), word-index width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  issue strobe from LSQ; op accepted on an edge where in_valid&in_ready.
- in_ready  out  1  stage can accept an op this cycle.
- in_pc  in  32  instruction PC.
- in_rob  in  6  ROB number.
- in_dest  in  6  destination physical reg (ignored for stores).
- in_addr  in  32  effective byte address.
- in_is_store  in  1  0 load, 1 store.
- in_size  in  1  0 word, 1 byte.
- in_sw_data  in  32  store data.
- in_from_lsq  in  1  load already satisfied by the queue; use in_lw_data, no memory access.
- in_lw_data  in  32  forwarded load data.
- cmp_valid  out  1  completion valid, one-cycle pulse per op.
- cmp_pc  out  32  PC of completing op.
- cmp_rob  out  6  ROB number.
- cmp_dest  out  6  dest reg (0 for stores).
- cmp_data  out  32  load result (0 for stores).
- cmp_is_store  out  1  completing op is a store.

Behaviour:
- Reset (async, rstn=0): cmp_* all 0; pipeline valids, skid valid and memory array cleared to 0. In-flight ops are dropped, not completed. in_ready=1 after reset.
- Addressing:
  - word index = in_addr[AW+1:2] (upper bits ignored; wraps modulo DEPTH_WORDS); byte lane = in_addr[1:0].
  - Word ops ignore in_addr[1:0] (force-aligned).
- Store (memory path):
  - Word: overwrites the word. Byte: writes in_sw_data[7:0] to the lane, other lanes unchanged.
  - Write happens on the accept edge, so a load accepted on any later edge sees it.
  - Store enters pipeline; completes MEM_LAT cycles later, cmp_is_store=1, cmp_data=0, cmp_dest=0.
- Load (memory path, from_lsq=0):
  - Memory read on the accept edge. Word: whole word. Byte: selected lane, sign-extended to 32 bits.
  - Carried through MEM_LAT pipeline stages; cmp_valid asserted in the cycle beginning MEM_LAT edges after accept.
- Forwarded load (from_lsq=1):
  - No memory access; entry loaded into the skid register on the accept edge.
  - Byte size: in_lw_data[7:0] sign-extended. Word: passed unchanged.
- Output arbitration each edge:
  - If pipeline tail valid, tail drives cmp_*.
  - Else if skid valid, skid drives cmp_* and skid clears, unless a new forwarded op loads it on the same edge.
  - Else cmp_valid=0 (other cmp_* hold last value).
- Latency: skid completion is 1 cycle after accept when there is no collision; on collision the skid waits until the tail is empty.
- in_ready = ~(skid_valid & tail_valid), combinational from registered state. Memory-path ops need no other backpressure (fully pipelined, 1/cycle).
- in_valid while in_ready=0: ignored; upstream holds the op.
- No op is ever lost or duplicated; each accepted op yields exactly one cmp_valid pulse.
- Completion order: memory-path ops complete in accept order. Forwarded loads may complete ahead of earlier memory-path ops; the ROB handles out-of-order completion.

Decomposition:
- Shared package (lsq_pkg): ROB_W=6, PREG_W=6, SIZE_WORD=0/SIZE_BYTE=1, OP_LOAD=0/OP_STORE=1, mem_op_t struct (valid, pc, rob, dest, is_store, data).
- One sub-module: lsq_mem_array (DEPTH_WORDS x 32, synchronous byte-lane write, registered read at accept edge, async clear on rstn).
- Pipeline and skid stay in the top module.

Test Plan:
- SW word 0xDEADBEEF @0x40 then LW @0x40 next cycle -> store cmp at +3 (cmp_is_store=1, data 0); load cmp at +3 with cmp_data=0xDEADBEEF.
- SB 0x80 @0x41 over word 0x11223344, then LB @0x41 and LW @0x40 -> LB data 0xFFFFFF80; LW data 0x11228044.
- Forwarded LW (from_lsq=1, lw_data 0x1234) with tail idle -> cmp_valid next cycle, data 0x1234, rob/dest echoed.
- LW memory @t, forwarded LW @t+2, LW memory @t+3 (MEM_LAT=3) -> collision at t+3: memory load first, forwarded at t+4; in_ready=0 during that cycle; third op accepted at t+4, completes t+7.
- Address 0x400 with DEPTH_WORDS=256 -> aliases word 0; SW 0xA5 to 0x400, LW @0x0 returns 0xA5.
- Assert rstn low with 3 ops in flight -> cmp_valid=0 immediately, no later completions; LW @0x40 after reset returns 0.
